// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, register indices and widths for the MIPS core
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int REG_NUM = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA = 5'd31;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI = 6'b001111;

    // logical immediates and lui take their 16 bits unsigned
    function automatic logic zero_ext_op(input logic [5:0] op);
        return op == OP_ANDI || op == OP_ORI || op == OP_XORI || op == OP_LUI;
    endfunction
endpackage

// File: rtl/reg_file.sv
// reg_file: 32-entry GPR array, three async read ports, one sync write port
module reg_file
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W,
    parameter bit WRITE_FORWARD = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [4:0]    waddr,
    input  logic [DW-1:0] wdata,
    input  logic [4:0]    ra1,
    input  logic [4:0]    ra2,
    input  logic [4:0]    ra3,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2,
    output logic [DW-1:0] rd3
);
    logic [DW-1:0] regs [REG_NUM];
    logic fwd;

    // forwarding is gated by rst_n so X controls during reset never leak out
    assign fwd = WRITE_FORWARD && rst_n && we && waddr != REG_ZERO;

    // reset clears everything and wins over a same-cycle write; $0 is never written
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (we && waddr != REG_ZERO) begin
            regs[waddr] <= wdata;
        end
    end

    // $0 reads zero; otherwise optionally bypass the pending write
    always_comb begin
        rd1 = ra1 == REG_ZERO ? '0 : (fwd && ra1 == waddr) ? wdata : regs[ra1];
        rd2 = ra2 == REG_ZERO ? '0 : (fwd && ra2 == waddr) ? wdata : regs[ra2];
        rd3 = ra3 == REG_ZERO ? '0 : (fwd && ra3 == waddr) ? wdata : regs[ra3];
    end
endmodule

// File: rtl/i_decode.sv
// i_decode: decode stage - register file, write-back muxing and immediate extension
module i_decode
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DATA_W,
    parameter bit WRITE_FORWARD = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [31:0]   instruction,
    input  logic [DW-1:0] pc_plus_4,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] mem_data,
    input  logic          reg_write,
    input  logic          reg_dst,
    input  logic          mem_to_reg,
    input  logic          jal,
    input  logic [4:0]    dbg_addr,
    output logic [DW-1:0] read_data_1,
    output logic [DW-1:0] read_data_2,
    output logic [DW-1:0] imm_extended,
    output logic [DW-1:0] dbg_data
);
    logic          we;
    logic [4:0]    dest;
    logic [DW-1:0] wdata;

    // jal overrides both destination and data selection with the link write
    always_comb begin
        we = reg_write | jal;
        dest = jal ? REG_RA : reg_dst ? instruction[15:11] : instruction[20:16];
        wdata = jal ? pc_plus_4 : mem_to_reg ? mem_data : alu_result;
        imm_extended = {{(DW-16){zero_ext_op(instruction[31:26]) ? 1'b0 : instruction[15]}},
                        instruction[15:0]};
    end

    reg_file #(.DW(DW), .WRITE_FORWARD(WRITE_FORWARD)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .waddr (dest),
        .wdata (wdata),
        .ra1   (instruction[25:21]),
        .ra2   (instruction[20:16]),
        .ra3   (dbg_addr),
        .rd1   (read_data_1),
        .rd2   (read_data_2),
        .rd3   (dbg_data)
    );
endmodule

// File: tb/tb_i_decode.sv
// tb_i_decode: scoreboard bench comparing forwarding and non-forwarding decoders against a model
module tb_i_decode;
    logic clk = 0;
    logic rst_n;
    logic [31:0] instruction, pc_plus_4, alu_result, mem_data;
    logic reg_write, reg_dst, mem_to_reg, jal;
    logic [4:0] dbg_addr;
    logic [31:0] r1a, r2a, ima, dba, r1b, r2b, imb, dbb;

    typedef struct {
        logic [31:0] r1a, r2a, dba, r1b, r2b, dbb, imm;
    } exp_t;
    exp_t q[$];
    logic [31:0] gpr [32];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    i_decode #(.WRITE_FORWARD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc_plus_4(pc_plus_4),
        .alu_result(alu_result), .mem_data(mem_data), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .jal(jal), .dbg_addr(dbg_addr),
        .read_data_1(r1a), .read_data_2(r2a), .imm_extended(ima), .dbg_data(dba)
    );

    i_decode #(.WRITE_FORWARD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .pc_plus_4(pc_plus_4),
        .alu_result(alu_result), .mem_data(mem_data), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .jal(jal), .dbg_addr(dbg_addr),
        .read_data_1(r1b), .read_data_2(r2b), .imm_extended(imb), .dbg_data(dbb)
    );

    function automatic logic [31:0] mread(input logic [4:0] idx, input bit fwd, input bit we,
                                          input logic [4:0] dest, input logic [31:0] wd);
        if (idx == 0) return 32'h0;
        if (fwd && we && dest == idx) return wd;
        return gpr[idx];
    endfunction

    function automatic logic [31:0] mimm(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        if (op inside {6'h0C, 6'h0D, 6'h0E, 6'h0F}) return {16'h0, ins[15:0]};
        return 32'($signed(ins[15:0]));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: outputs are settled mid-cycle, so compare on the falling edge
    initial forever begin
        @(negedge clk);
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("rd1_nofwd", r1a, e.r1a);
            chk("rd2_nofwd", r2a, e.r2a);
            chk("dbg_nofwd", dba, e.dba);
            chk("imm_nofwd", ima, e.imm);
            chk("rd1_fwd", r1b, e.r1b);
            chk("rd2_fwd", r2b, e.r2b);
            chk("dbg_fwd", dbb, e.dbb);
            chk("imm_fwd", imb, e.imm);
        end
    end

    task automatic cyc(input logic [31:0] ins, input logic rn, input logic rw, input logic rdst,
                       input logic m2r, input logic j, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [31:0] pc, input logic [4:0] dbg);
        bit we;
        logic [4:0] dest;
        logic [31:0] wd;
        exp_t e;
        instruction = ins; rst_n = rn; reg_write = rw; reg_dst = rdst; mem_to_reg = m2r;
        jal = j; alu_result = alu; mem_data = mem; pc_plus_4 = pc; dbg_addr = dbg;
        we = rw | j;
        dest = j ? 5'd31 : rdst ? ins[15:11] : ins[20:16];
        wd = j ? pc : m2r ? mem : alu;
        if (rn) begin
            e.r1a = mread(ins[25:21], 0, we, dest, wd);
            e.r2a = mread(ins[20:16], 0, we, dest, wd);
            e.dba = mread(dbg, 0, we, dest, wd);
            e.r1b = mread(ins[25:21], 1, we, dest, wd);
            e.r2b = mread(ins[20:16], 1, we, dest, wd);
            e.dbb = mread(dbg, 1, we, dest, wd);
            e.imm = mimm(ins);
            q.push_back(e);
        end
        @(posedge clk);
        if (!rn) foreach (gpr[i]) gpr[i] = 32'h0;
        else if (we && dest != 0) gpr[dest] = wd;
        #1;
    endtask

    initial begin
        foreach (gpr[i]) gpr[i] = 32'h0;
        rst_n = 0; instruction = 0; pc_plus_4 = 0; alu_result = 0; mem_data = 0;
        reg_write = 0; reg_dst = 0; mem_to_reg = 0; jal = 0; dbg_addr = 0;
        @(posedge clk); #1;
        cyc(32'h00221820, 0, 1, 1, 0, 0, 32'h1, 0, 0, 0);
        cyc(32'h00221820, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'h00221820, 1, 0, 0, 0, 0, 0, 0, 0, 5);
        cyc(32'h00221820, 1, 1, 1, 0, 0, 32'h1234, 0, 0, 3);
        cyc(32'h00221820, 1, 0, 1, 0, 0, 0, 0, 0, 3);
        cyc(32'h8C080000, 1, 1, 0, 1, 0, 32'h5, 32'hDEADBEEF, 0, 8);
        cyc(32'h8C000000, 1, 1, 0, 1, 0, 32'h5, 32'hCAFEF00D, 0, 8);
        cyc(32'h8C000000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'h0C000011, 1, 0, 1, 1, 1, 32'h9, 32'h7, 32'h44, 31);
        cyc(32'h03E00008, 1, 0, 0, 0, 0, 0, 0, 0, 31);
        cyc(32'h20008000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'h34008000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'h3C00FFFF, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'hAC000004, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(32'h20840000, 1, 1, 0, 0, 0, 32'h55, 0, 0, 4);
        cyc(32'h20840000, 1, 0, 0, 0, 0, 0, 0, 0, 4);
        cyc(32'h20840000, 0, 1, 0, 0, 0, 32'h77, 0, 0, 4);
        cyc(32'h20840000, 1, 0, 0, 0, 0, 0, 0, 0, 4);
        for (int n = 0; n < 400; n++)
            cyc($urandom, ($urandom_range(0, 31) != 0), 1'($urandom), 1'($urandom),
                1'($urandom), ($urandom_range(0, 7) == 0), $urandom, $urandom, $urandom,
                5'($urandom));
        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
